pwm_deadtime: RTL and testbench

//   Downstream output stage for the 4-channel APB PWM peripheral. Takes each raw
//   PWM_OUTx level and drives a complementary high-side/low-side gate pair.

---
 rtl/pwm_deadtime_if.sv | 26 ++
 rtl/pwm_deadtime.sv | 121 ++++++++++++
 tb/tb_pwm_deadtime.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadtime_if.sv
// Control and gate-drive bundle between the PWM dead-time stage and its neighbours.
// Latency: n/a (wires only). Backpressure: none, levels only.
// The master drives the controls and PWM levels; the slave (dead-time stage) drives the gates.
interface pwm_deadtime_if #(
    parameter int P_CH          = 4,
    parameter int P_DT_BITWIDTH = 8
);
    logic                     EN;
    logic [P_DT_BITWIDTH-1:0] DEAD_TIME;
    logic                     FAULT;
    logic                     FAULT_CLR;
    logic [P_CH-1:0]          PWM_IN;
    logic [P_CH-1:0]          PWM_H;
    logic [P_CH-1:0]          PWM_L;
    logic                     FAULT_STAT;

    modport master (
        output EN, DEAD_TIME, FAULT, FAULT_CLR, PWM_IN,
        input  PWM_H, PWM_L, FAULT_STAT
    );

    modport slave (
        input  EN, DEAD_TIME, FAULT, FAULT_CLR, PWM_IN,
        output PWM_H, PWM_L, FAULT_STAT
    );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with per-channel dead time and a latched fault kill.
// Latency: departing gate drops 1 edge after the PWM edge, arriving gate rises max(DEAD_TIME,1) edges after.
// Backpressure: none; kill (EN low or fault latched) forces every channel OFF at the next edge.
module pwm_deadtime #(
    parameter int P_CH          = 4,
    parameter int P_DT_BITWIDTH = 8
) (
    input  logic          PCLK,
    input  logic          PRESET,
    pwm_deadtime_if.slave bus
);
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_LOW     = 3'd1,
        ST_DT_RISE = 3'd2,
        ST_HIGH    = 3'd3,
        ST_DT_FALL = 3'd4
    } st_t;

    localparam logic [P_DT_BITWIDTH-1:0] CNT_ONE = P_DT_BITWIDTH'(1);

    st_t                      st_q  [P_CH];
    st_t                      st_d  [P_CH];
    logic [P_DT_BITWIDTH-1:0] cnt_q [P_CH];
    logic [P_DT_BITWIDTH-1:0] cnt_d [P_CH];
    logic                     fault_q;
    logic                     fault_d;
    logic                     kill;

    // FAULT wins over FAULT_CLR so a still-active fault can never be cleared.
    always_comb begin
        fault_d = fault_q;
        if (bus.FAULT) begin
            fault_d = 1'b1;
        end else if (bus.FAULT_CLR) begin
            fault_d = 1'b0;
        end
    end

    assign kill = ~bus.EN | fault_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            fault_q <= 1'b0;
            for (int i = 0; i < P_CH; i++) begin
                st_q[i]  <= ST_OFF;
                cnt_q[i] <= '0;
            end
        end else begin
            fault_q <= fault_d;
            for (int i = 0; i < P_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < P_CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (kill) begin
                st_d[i]  = ST_OFF;
                cnt_d[i] = '0;
            end else begin
                case (st_q[i])
                    // Leaving OFF always passes through a DT state so re-enable honours dead time.
                    ST_OFF: begin
                        st_d[i]  = bus.PWM_IN[i] ? ST_DT_RISE : ST_DT_FALL;
                        cnt_d[i] = bus.DEAD_TIME;
                    end
                    ST_LOW: begin
                        if (bus.PWM_IN[i]) begin
                            st_d[i]  = ST_DT_RISE;
                            cnt_d[i] = bus.DEAD_TIME;
                        end
                    end
                    ST_HIGH: begin
                        if (!bus.PWM_IN[i]) begin
                            st_d[i]  = ST_DT_FALL;
                            cnt_d[i] = bus.DEAD_TIME;
                        end
                    end
                    ST_DT_RISE: begin
                        if (!bus.PWM_IN[i]) begin
                            st_d[i] = ST_LOW;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            st_d[i] = ST_HIGH;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    ST_DT_FALL: begin
                        if (bus.PWM_IN[i]) begin
                            st_d[i] = ST_HIGH;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            st_d[i] = ST_LOW;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        st_d[i]  = ST_OFF;
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Gates decode straight from state flops: no combinational PWM_IN-to-pad path.
    always_comb begin
        bus.PWM_H      = '0;
        bus.PWM_L      = '0;
        bus.FAULT_STAT = fault_q;
        for (int i = 0; i < P_CH; i++) begin
            bus.PWM_H[i] = (st_q[i] == ST_HIGH);
            bus.PWM_L[i] = (st_q[i] == ST_LOW);
        end
    end
endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and random checks of the dead-time stage with a queue of expected gate vectors.
module tb_pwm_deadtime;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [8:0] exp_q [$];
    string      tag_q [$];

    pwm_deadtime_if #(.P_CH(4), .P_DT_BITWIDTH(8)) bus ();

    pwm_deadtime #(.P_CH(4), .P_DT_BITWIDTH(8)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [3:0] eh, input logic [3:0] el, input logic es, input string tag);
        logic [8:0] o;
        logic [8:0] e;
        e = {eh, el, es};
        o = {bus.PWM_H, bus.PWM_L, bus.FAULT_STAT};
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed H=%b L=%b S=%b expected H=%b L=%b S=%b",
                   tag, o[8:5], o[4:1], o[0], e[8:5], e[4:1], e[0]);
        end
    endtask

    // Push the expectation for the coming edge, then pop it once the DUT has produced it.
    task automatic tick(input logic [3:0] eh, input logic [3:0] el, input logic es, input string tag);
        logic [8:0] e;
        logic [8:0] o;
        string      t;
        exp_q.push_back({eh, el, es});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {bus.PWM_H, bus.PWM_L, bus.FAULT_STAT};
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed H=%b L=%b S=%b expected H=%b L=%b S=%b",
                   t, o[8:5], o[4:1], o[0], e[8:5], e[4:1], e[0]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.EN        = 1'b0;
        bus.DEAD_TIME = 8'd0;
        bus.FAULT     = 1'b0;
        bus.FAULT_CLR = 1'b0;
        bus.PWM_IN    = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(4'h0, 4'h0, 1'b0, "reset_state");

        // Bring-up: OFF -> DT_FALL for 3 edges -> LOW.
        rst           = 1'b0;
        bus.EN        = 1'b1;
        bus.DEAD_TIME = 8'd3;
        tick(4'h0, 4'h0, 1'b0, "boot_dt1");
        tick(4'h0, 4'h0, 1'b0, "boot_dt2");
        tick(4'h0, 4'h0, 1'b0, "boot_dt3");
        tick(4'h0, 4'hF, 1'b0, "boot_low");
        tick(4'h0, 4'hF, 1'b0, "boot_low_hold");

        // ch0 rises with DEAD_TIME=3: L drops at k, H rises at k+3.
        bus.PWM_IN = 4'h1;
        tick(4'h0, 4'hE, 1'b0, "rise_k");
        tick(4'h0, 4'hE, 1'b0, "rise_k1");
        tick(4'h0, 4'hE, 1'b0, "rise_k2");
        tick(4'h1, 4'hE, 1'b0, "rise_k3_h");

        // DEAD_TIME=0 behaves as exactly one both-off cycle per transition.
        bus.DEAD_TIME = 8'd0;
        bus.PWM_IN    = 4'hF;
        tick(4'h1, 4'h0, 1'b0, "dt0_first_gap");
        for (int j = 0; j < 9; j++) tick(4'hF, 4'h0, 1'b0, "dt0_first_high");
        for (int i = 0; i < 3; i++) begin
            logic lvl;
            lvl = (i % 2) == 1;
            bus.PWM_IN = lvl ? 4'hF : 4'h0;
            tick(4'h0, 4'h0, 1'b0, "dt0_gap");
            for (int j = 0; j < 9; j++)
                tick(lvl ? 4'hF : 4'h0, lvl ? 4'h0 : 4'hF, 1'b0, "dt0_level");
        end

        // Short pulse on ch1 with DEAD_TIME=5 aborts back to LOW; H never turns on.
        bus.DEAD_TIME = 8'd5;
        bus.PWM_IN    = 4'h2;
        tick(4'h0, 4'hD, 1'b0, "abort_k");
        tick(4'h0, 4'hD, 1'b0, "abort_k1");
        bus.PWM_IN = 4'h0;
        tick(4'h0, 4'hF, 1'b0, "abort_low_back");
        tick(4'h0, 4'hF, 1'b0, "abort_low_hold");

        // Fault latch behaviour while all channels drive HIGH.
        bus.DEAD_TIME = 8'd2;
        bus.PWM_IN    = 4'hF;
        tick(4'h0, 4'h0, 1'b0, "flt_pre_dt1");
        tick(4'h0, 4'h0, 1'b0, "flt_pre_dt2");
        tick(4'hF, 4'h0, 1'b0, "flt_pre_high");
        bus.FAULT = 1'b1;
        tick(4'hF, 4'h0, 1'b1, "flt_latched");
        bus.FAULT = 1'b0;
        tick(4'h0, 4'h0, 1'b1, "flt_gates_off");
        tick(4'h0, 4'h0, 1'b1, "flt_hold");
        bus.FAULT     = 1'b1;
        bus.FAULT_CLR = 1'b1;
        tick(4'h0, 4'h0, 1'b1, "flt_clr_blocked");
        bus.FAULT     = 1'b0;
        bus.FAULT_CLR = 1'b0;
        tick(4'h0, 4'h0, 1'b1, "flt_still_set");
        bus.FAULT_CLR = 1'b1;
        tick(4'h0, 4'h0, 1'b0, "flt_cleared");
        bus.FAULT_CLR = 1'b0;
        tick(4'h0, 4'h0, 1'b0, "flt_rec_dt1");
        tick(4'h0, 4'h0, 1'b0, "flt_rec_dt2");
        tick(4'hF, 4'h0, 1'b0, "flt_rec_high");

        // EN drop and return with DEAD_TIME=0: one gap edge before H.
        bus.DEAD_TIME = 8'd0;
        bus.EN        = 1'b0;
        tick(4'h0, 4'h0, 1'b0, "en_off");
        tick(4'h0, 4'h0, 1'b0, "en_off_hold");
        bus.EN = 1'b1;
        tick(4'h0, 4'h0, 1'b0, "en_dt0_gap");
        tick(4'hF, 4'h0, 1'b0, "en_dt0_high");

        // DEAD_TIME=4 sampled on DT entry; changing it mid-count must not matter.
        bus.DEAD_TIME = 8'd4;
        bus.EN        = 1'b0;
        tick(4'h0, 4'h0, 1'b0, "en4_off");
        bus.EN = 1'b1;
        tick(4'h0, 4'h0, 1'b0, "en4_dt1");
        bus.DEAD_TIME = 8'd1;
        tick(4'h0, 4'h0, 1'b0, "en4_dt2");
        tick(4'h0, 4'h0, 1'b0, "en4_dt3");
        tick(4'h0, 4'h0, 1'b0, "en4_dt4");
        tick(4'hF, 4'h0, 1'b0, "en4_high");

        // Asynchronous reset in the middle of a dead-time interval.
        bus.DEAD_TIME = 8'd6;
        bus.PWM_IN    = 4'h0;
        tick(4'h0, 4'h0, 1'b0, "pre_rst_dt");
        bus.FAULT = 1'b1;
        tick(4'h0, 4'h0, 1'b1, "pre_rst_flt");
        bus.FAULT = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check(4'h0, 4'h0, 1'b0, "rst_midop");
        #1;
        rst = 1'b0;
        tick(4'h0, 4'h0, 1'b0, "rst_release_dt");

        // Random traffic: the gates must never overlap; reset must clear outputs at once.
        for (int c = 0; c < 3000; c++) begin
            bus.PWM_IN    = 4'($urandom);
            bus.EN        = ($urandom_range(0, 15) != 0);
            bus.FAULT     = ($urandom_range(0, 63) == 0);
            bus.FAULT_CLR = ($urandom_range(0, 7) == 0);
            bus.DEAD_TIME = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check(4'h0, 4'h0, 1'b0, "rand_preset");
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            n_vec++;
            assert ((bus.PWM_H & bus.PWM_L) === 4'h0) else begin
                n_err++;
                $error("FAIL rand_overlap: observed H&L=%b expected 0000", bus.PWM_H & bus.PWM_L);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
